// File: rtl/uart_tx_responder.sv
// Memory-mapped UART transmitter with a TX FIFO; 8N1 frames on uart_tx.
// Define UART_TX_PARITY_EN to add an even parity bit between data and stop (8E1).
module uart_tx_responder #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wrdata,
  input  logic        uart_wren,
  output logic [31:0] uart_rddata,
  output logic        uart_tx,
  output logic        uart_busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP  = 3'd3
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic [7:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_s;
  logic             overflow_r, overflow_s;
  logic [15:0]      baud_div_r;
  state_t           state_r, state_s;
  logic [7:0]       shift_r, shift_s, head_s;
  logic [15:0]      bit_div_r, bit_div_s, baud_cnt_r, baud_cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic             tx_r, tx_s, busy_r;
`ifdef UART_TX_PARITY_EN
  logic             parity_r;
`endif
  logic [1:0]       reg_sel_s;
  logic             push_s, push_ok_s, pop_s, load_s, tick_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [31:0]      status_s;
  logic             unused_bits_s;

  assign reg_sel_s     = uart_addr[3:2];
  assign push_s        = uart_wren && (reg_sel_s == 2'd0);
  assign fifo_full_s   = (count_r == DEPTH_C);
  assign fifo_empty_s  = (count_r == {CNT_W{1'b0}});
  assign push_ok_s     = push_s && (!fifo_full_s || pop_s);
  assign head_s        = fifo_mem_r[rd_ptr_r];
  assign tick_s        = (baud_cnt_r == 16'd0);
  assign unused_bits_s = ^{uart_addr[31:4], uart_addr[1:0], uart_wrdata[31:16]};

  // FIFO occupancy and sticky overflow next-state
  always_comb begin
    count_s    = count_r;
    overflow_s = overflow_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_s = count_r;
    endcase
    // A dropped push in the same cycle as a clear keeps the flag set.
    if (push_s && fifo_full_s && !pop_s) begin
      overflow_s = 1'b1;
    end else if (uart_wren && (reg_sel_s == 2'd1) && uart_wrdata[3]) begin
      overflow_s = 1'b0;
    end else begin
      overflow_s = overflow_r;
    end
  end

  // Frame sequencer: next state, baud counter, shift register, pop request
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_div_s  = bit_div_r;
    bit_idx_s  = bit_idx_r;
    baud_cnt_s = tick_s ? 16'd0 : (baud_cnt_r - 16'd1);
    load_s     = 1'b0;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: load_s = !fifo_empty_s;
      START: begin
        if (tick_s) begin
          state_s    = DATA;
          bit_idx_s  = 3'd0;
          baud_cnt_s = bit_div_r - 16'd1;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          baud_cnt_s = bit_div_r - 16'd1;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            shift_s   = {1'b0, shift_r[7:1]};
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_s) begin
          state_s    = STOP;
          baud_cnt_s = bit_div_r - 16'd1;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick_s) begin
          if (!fifo_empty_s) begin
            load_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase
    // Divisor is sampled only at frame start, so mid-frame BAUDDIV writes wait.
    if (load_s) begin
      pop_s      = 1'b1;
      state_s    = START;
      shift_s    = head_s;
      bit_div_s  = baud_div_r;
      baud_cnt_s = baud_div_r - 16'd1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Line level for the upcoming cycle, registered below
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_s = parity_r;
`endif
      default: tx_s = 1'b1;
    endcase
  end

  // FIFO storage, pointers, count, overflow and divisor register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= 8'd0;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
      baud_div_r <= DEFAULT_DIV;
    end else begin
      if (push_ok_s) begin
        fifo_mem_r[wr_ptr_r] <= uart_wrdata[7:0];
        wr_ptr_r             <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      count_r    <= count_s;
      overflow_r <= overflow_s;
      if (uart_wren && (reg_sel_s == 2'd2)) begin
        baud_div_r <= (uart_wrdata[15:0] == 16'd0) ? 16'd1 : uart_wrdata[15:0];
      end
    end
  end

  // Sequencer state and registered line/busy outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      shift_r    <= 8'd0;
      bit_div_r  <= DEFAULT_DIV;
      baud_cnt_r <= 16'd0;
      bit_idx_r  <= 3'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_div_r  <= bit_div_s;
      baud_cnt_r <= baud_cnt_s;
      bit_idx_r  <= bit_idx_s;
      tx_r       <= tx_s;
      busy_r     <= (state_s != IDLE) || (count_s != {CNT_W{1'b0}});
`ifdef UART_TX_PARITY_EN
      if (load_s) parity_r <= even_parity(head_s);
`endif
    end
  end

  assign status_s = {23'd0, PARITY_FLAG, 4'(count_r), overflow_r,
                     (state_r != IDLE), fifo_empty_s, fifo_full_s};

  // Combinational register read-back
  always_comb begin
    uart_rddata = 32'd0;
    case (reg_sel_s)
      2'd1:    uart_rddata = status_s;
      2'd2:    uart_rddata = {16'd0, baud_div_r};
      default: uart_rddata = 32'd0;
    endcase
  end

  assign uart_tx   = tx_r;
  assign uart_busy = busy_r;
endmodule

// File: tb/tb_uart_tx_responder.sv
// Self-checking bench for uart_tx_responder: a line monitor decodes every frame
// cycle by cycle against a queue of expected bytes/divisors filled by the tests.
`timescale 1ns/1ps
module tb_uart_tx_responder;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam logic [31:0] PAR_FLAG   = 32'h100;
`else
  localparam int          FRAME_BITS = 10;
  localparam logic [31:0] PAR_FLAG   = 32'h000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] uart_addr = 32'd0;
  logic [31:0] uart_wrdata = 32'd0;
  logic        uart_wren = 1'b0;
  logic [31:0] uart_rddata;
  logic        uart_tx;
  logic        uart_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_done = 0;
  logic [7:0] exp_q[$];
  int         div_q[$];
  int         start_q[$];

  always #5 clk = ~clk;

  uart_tx_responder #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .rst(rst), .uart_addr(uart_addr), .uart_wrdata(uart_wrdata),
    .uart_wren(uart_wren), .uart_rddata(uart_rddata), .uart_tx(uart_tx),
    .uart_busy(uart_busy)
  );

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else if (idx == FRAME_BITS - 1) return 1'b1;
    else return ^b;
  endfunction

  // Line monitor: pops the scoreboard at each start bit, checks every cycle of the frame
  initial begin : monitor
    logic       in_frame;
    logic [7:0] cur_byte;
    int         cur_div;
    int         pos;
    logic       eb;
    in_frame = 1'b0; cur_byte = 8'd0; cur_div = 1; pos = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst !== 1'b1) begin
        in_frame = 1'b0;
      end else if (!in_frame && uart_tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, got tx=0 want idle 1", cyc);
        end else begin
          cur_byte = exp_q.pop_front();
          cur_div  = div_q.pop_front();
          in_frame = 1'b1;
          pos      = 0;
          start_q.push_back(cyc);
        end
      end
      if (in_frame) begin
        eb = frame_bit(cur_byte, pos / cur_div);
        checks++;
        if (uart_tx !== eb) begin
          errors++;
          $display("FAIL frame_bit: byte %h bit %0d cycle %0d got %b want %b",
                   cur_byte, pos / cur_div, cyc, uart_tx, eb);
        end
        pos++;
        if (pos == FRAME_BITS * cur_div) begin
          in_frame = 1'b0;
          frames_done++;
        end
      end
    end
  end

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic bus_write(input logic [1:0] sel, input logic [31:0] data);
    uart_addr   = {28'd0, sel, 2'b00};
    uart_wrdata = data;
    uart_wren   = 1'b1;
    @(negedge clk);
    uart_wren   = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [31:0] data);
    uart_addr = {28'd0, sel, 2'b00};
    #1;
    data = uart_rddata;
  endtask

  task automatic push_byte(input logic [7:0] b, input int div);
    exp_q.push_back(b);
    div_q.push_back(div);
    bus_write(2'd0, {24'd0, b});
  endtask

  task automatic wait_frames(input int target, input int limit);
    for (int i = 0; i < limit && frames_done < target; i++) @(negedge clk);
  endtask

  task automatic wait_starts(input int target, input int limit);
    for (int i = 0; i < limit && start_q.size() < target; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      uart_addr   = $urandom;
      uart_wrdata = $urandom;
      uart_wren   = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
      checks++;
      if (uart_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", uart_busy); end
    end
    uart_wren = 1'b0;
    bus_read(2'd1, rd);
    checks++;
    if (rd !== (32'h2 | PAR_FLAG)) begin errors++; $display("FAIL reset_status: got %h want %h", rd, 32'h2 | PAR_FLAG); end
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'd434) begin errors++; $display("FAIL reset_bauddiv: got %0d want 434", rd); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] rd;
    int base_f;
    base_f = frames_done;
    bus_write(2'd2, 32'd4);
    push_byte(8'hA5, 4);
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_early_start: got %b want 1", uart_tx); end
    @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0) begin errors++; $display("FAIL single_start_latency: got %b want 0", uart_tx); end
    wait_frames(base_f + 1, 80);
    checks++;
    if (frames_done !== base_f + 1) begin errors++; $display("FAIL single_frame_count: got %0d want %0d", frames_done, base_f + 1); end
    @(negedge clk);
    checks++;
    if (uart_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", uart_busy); end
    bus_read(2'd1, rd);
    checks++;
    if (rd !== (32'h2 | PAR_FLAG)) begin errors++; $display("FAIL single_status_after: got %h want %h", rd, 32'h2 | PAR_FLAG); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int base_f, base_s;
    bus_write(2'd2, 32'd2);
    base_f = frames_done;
    base_s = start_q.size();
    push_byte(8'h00, 2);
    push_byte(8'hFF, 2);
    push_byte(8'h55, 2);
    bus_read(2'd1, rd);
    checks++;
    if (rd[7:4] !== 4'd2) begin errors++; $display("FAIL b2b_count_first: got %0d want 2", rd[7:4]); end
    wait_starts(base_s + 2, 60);
    bus_read(2'd1, rd);
    checks++;
    if (rd[7:4] !== 4'd1) begin errors++; $display("FAIL b2b_count_second: got %0d want 1", rd[7:4]); end
    wait_starts(base_s + 3, 60);
    bus_read(2'd1, rd);
    checks++;
    if (rd[7:4] !== 4'd0) begin errors++; $display("FAIL b2b_count_third: got %0d want 0", rd[7:4]); end
    wait_frames(base_f + 3, 100);
    checks++;
    if (frames_done !== base_f + 3) begin
      errors++; $display("FAIL b2b_frame_count: got %0d want %0d", frames_done, base_f + 3);
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (start_q[base_s + k] - start_q[base_s + k - 1] !== FRAME_BITS * 2) begin
          errors++;
          $display("FAIL b2b_gap: frame %0d spacing got %0d want %0d", k,
                   start_q[base_s + k] - start_q[base_s + k - 1], FRAME_BITS * 2);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    int base_f;
    bus_write(2'd2, 32'd2);
    base_f = frames_done;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) begin
        exp_q.push_back(8'h30 + 8'(i));
        div_q.push_back(2);
      end
      bus_write(2'd0, 32'h30 + 32'(i));
    end
    bus_read(2'd1, rd);
    checks++;
    if (rd !== (32'h8D | PAR_FLAG)) begin errors++; $display("FAIL ovf_status_set: got %h want %h", rd, 32'h8D | PAR_FLAG); end
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, rd);
    checks++;
    if (rd !== (32'h85 | PAR_FLAG)) begin errors++; $display("FAIL ovf_status_clear: got %h want %h", rd, 32'h85 | PAR_FLAG); end
    wait_frames(base_f + 9, 9 * FRAME_BITS * 2 + 60);
    checks++;
    if (frames_done !== base_f + 9) begin errors++; $display("FAIL ovf_frame_count: got %0d want %0d", frames_done, base_f + 9); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL ovf_scoreboard_left: got %0d want 0", exp_q.size()); end
    @(negedge clk);
    checks++;
    if (uart_busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_after: got %b want 0", uart_busy); end
    bus_read(2'd1, rd);
    checks++;
    if (rd !== (32'h2 | PAR_FLAG)) begin errors++; $display("FAIL ovf_status_after: got %h want %h", rd, 32'h2 | PAR_FLAG); end
    @(negedge clk);
  endtask

  task automatic test_parity_flag();
    logic [31:0] rd;
    bus_read(2'd1, rd);
    checks++;
    if (rd[8] !== PAR_FLAG[8]) begin errors++; $display("FAIL parity_status_flag: got %b want %b", rd[8], PAR_FLAG[8]); end
`ifdef UART_TX_PARITY_EN
    begin
      int base_f;
      @(negedge clk);
      bus_write(2'd2, 32'd1);
      base_f = frames_done;
      push_byte(8'h07, 1);
      wait_frames(base_f + 1, 40);
      checks++;
      if (frames_done !== base_f + 1) begin errors++; $display("FAIL parity_frame_count: got %0d want %0d", frames_done, base_f + 1); end
      @(negedge clk);
      checks++;
      if (uart_busy !== 1'b0) begin errors++; $display("FAIL parity_busy_after: got %b want 0", uart_busy); end
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_divisor_and_reset();
    logic [31:0] rd;
    int base_s;
    bus_write(2'd2, 32'd4);
    base_s = start_q.size();
    push_byte(8'h3C, 4);
    push_byte(8'h5A, 8);
    bus_write(2'd0, 32'h81);
    repeat (6) @(negedge clk);
    bus_write(2'd2, 32'd8);
    wait_starts(base_s + 2, 100);
    checks++;
    if (start_q.size() !== base_s + 2) begin
      errors++; $display("FAIL div_second_start: got %0d starts want %0d", start_q.size(), base_s + 2);
    end else begin
      checks++;
      if (start_q[base_s + 1] - start_q[base_s] !== FRAME_BITS * 4) begin
        errors++; $display("FAIL div_first_len: got %0d want %0d", start_q[base_s + 1] - start_q[base_s], FRAME_BITS * 4);
      end
    end
    repeat (8 * 3 + 3) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0) begin errors++; $display("FAIL div_mid_bit2: got %b want 0", uart_tx); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_tx_immediate: got %b want 1", uart_tx); end
    checks++;
    if (uart_busy !== 1'b0) begin errors++; $display("FAIL rst_busy_immediate: got %b want 0", uart_busy); end
    exp_q.delete();
    div_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus_read(2'd1, rd);
    checks++;
    if (rd !== (32'h2 | PAR_FLAG)) begin errors++; $display("FAIL rst_fifo_empty: got %h want %h", rd, 32'h2 | PAR_FLAG); end
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'd434) begin errors++; $display("FAIL rst_bauddiv: got %0d want 434", rd); end
    repeat (30) @(negedge clk);
    checks++;
    if (uart_busy !== 1'b0) begin errors++; $display("FAIL rst_stays_idle: got busy %b want 0", uart_busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_parity_flag();
    test_divisor_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
